me_frame_sched: RTL

//  Frame-level scheduler for the ME engine: walks the macroblock grid in raster order, enables
//  the engine per MB, collects MSAD/row/column on data_valid and emits one result per MB over
//  a valid/ready port. mb_x_o/mb_y_o give cur_mem/ref_mem their per-MB base coordinates.

---
 rtl/me_frame_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/me_frame_sched.sv
// ---------------------------------------------------------------------------
// me_frame_sched
//   Frame-level scheduler for the motion-estimation engine. Walks the
//   macroblock grid in raster order. For each MB it enables the engine, then
//   captures MSAD/row/column when the engine reports data_valid. The captured
//   result is presented on a valid/ready port. The MB coordinates (mb_x_o,
//   mb_y_o) give the current/reference memories their per-MB base address.
//
// Optional feature macro: ME_TIMEOUT_EN
//   When defined, a WAIT-state watchdog is built in. If the engine stays
//   silent for TIMEOUT_CYC cycles, the scheduler emits a saturated result
//   (SAD all ones, row = col = 0) and sets the sticky timeout_o flag.
//   When undefined, WAIT lasts until me_valid_i and timeout_o is tied to 0.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active low
//   frame_start_i in   start-of-frame pulse, honoured only while idle
//   busy_o        out  high while a frame is in progress
//   frame_done_o  out  one-cycle pulse after the last MB result is accepted
//   mb_x_o/mb_y_o out  current macroblock column / row
//   me_en_o       out  engine enable, high for the whole WAIT state
//   me_valid_i    in   engine data_valid
//   me_sad_i      in   engine MSAD
//   me_row_i      in   engine MSAD_row
//   me_col_i      in   engine MSAD_column
//   res_valid_o   out  result valid
//   res_ready_i   in   result consumer ready
//   res_sad_o     out  captured MSAD
//   res_row_o     out  captured MSAD_row
//   res_col_o     out  captured MSAD_column
//   timeout_o     out  sticky watchdog flag
// ---------------------------------------------------------------------------
module me_frame_sched #(
  parameter int MB_COLS     = 22,
  parameter int MB_ROWS     = 18,
  parameter int MBX_W       = 5,
  parameter int MBY_W       = 5,
  parameter int SAD_W       = 14,
  parameter int MV_W        = 5,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start_i,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic [MBX_W-1:0] mb_x_o,
  output logic [MBY_W-1:0] mb_y_o,
  output logic             me_en_o,
  input  logic             me_valid_i,
  input  logic [SAD_W-1:0] me_sad_i,
  input  logic [MV_W-1:0]  me_row_i,
  input  logic [MV_W-1:0]  me_col_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [SAD_W-1:0] res_sad_o,
  output logic [MV_W-1:0]  res_row_o,
  output logic [MV_W-1:0]  res_col_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [MBX_W-1:0] LAST_X = MBX_W'(MB_COLS - 1);
  localparam logic [MBY_W-1:0] LAST_Y = MBY_W'(MB_ROWS - 1);

  state_t           r_state;
  logic [MBX_W-1:0] r_mb_x;
  logic [MBY_W-1:0] r_mb_y;
  logic [SAD_W-1:0] r_sad;
  logic [MV_W-1:0]  r_row;
  logic [MV_W-1:0]  r_col;

  logic w_last_col;
  logic w_last_mb;

  assign w_last_col = (r_mb_x == LAST_X);
  assign w_last_mb  = w_last_col && (r_mb_y == LAST_Y);

`ifdef ME_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout;
`else
  // The watchdog limit has no meaning without the watchdog.
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_mb_x  <= '0;
      r_mb_y  <= '0;
      r_sad   <= '0;
      r_row   <= '0;
      r_col   <= '0;
`ifdef ME_TIMEOUT_EN
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_start_i) begin
            r_state <= S_WAIT;
            r_mb_x  <= '0;
            r_mb_y  <= '0;
`ifdef ME_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
`endif
          end
        end

        S_WAIT: begin
          // A real answer in the same cycle as the watchdog expiry takes priority.
          if (me_valid_i) begin
            r_sad   <= me_sad_i;
            r_row   <= me_row_i;
            r_col   <= me_col_i;
            r_state <= S_EMIT;
          end
`ifdef ME_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_sad     <= '1;
            r_row     <= '0;
            r_col     <= '0;
            r_timeout <= 1'b1;
            r_state   <= S_EMIT;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end

        S_EMIT: begin
          if (res_ready_i) begin
            if (w_last_mb) begin
              // Coordinates hold on the last MB until DONE clears them.
              r_state <= S_DONE;
            end else begin
              if (w_last_col) begin
                r_mb_x <= '0;
                r_mb_y <= r_mb_y + 1'b1;
              end else begin
                r_mb_x <= r_mb_x + 1'b1;
              end
              r_state <= S_WAIT;
`ifdef ME_TIMEOUT_EN
              r_tmo_cnt <= '0;
`endif
            end
          end
        end

        S_DONE: begin
          r_mb_x  <= '0;
          r_mb_y  <= '0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Every output is a pure decode of registered state.
  // This keeps the module free of combinational input-to-output paths.
  assign busy_o       = (r_state != S_IDLE);
  assign me_en_o      = (r_state == S_WAIT);
  assign res_valid_o  = (r_state == S_EMIT);
  assign frame_done_o = (r_state == S_DONE);
  assign mb_x_o       = r_mb_x;
  assign mb_y_o       = r_mb_y;
  assign res_sad_o    = r_sad;
  assign res_row_o    = r_row;
  assign res_col_o    = r_col;

`ifdef ME_TIMEOUT_EN
  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
